armleocpu_bus_arbiter: RTL and testbench
========================================

Name: armleocpu_bus_arbiter

Overview:
Parametrised N-master to 1-slave arbiter for the core memory bus (transaction/cmd/done/response/burstcount protocol). It replaces the separate i_/d_ top-level bus ports with a single shared external port. It can also aggregate extra masters such as a debug or PTW port. It provides round-robin or fixed-priority arbitration and holds the grant for a whole burst.

Parameters:
CHANNELS, 2, number of master ports (2..8); index 0 = dcache, 1 = icache by convention.
ADDR_W, 34, bus address width.
DATA_W, 32, data width; byte enable width = DATA_W/8.
ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
m_transaction  in  CHANNELS  per-master request.
m_cmd  in  3*CHANNELS  per-master command, channel k at [3k+2:3k].
m_address  in  ADDR_W*CHANNELS  per-master address.
m_burstcount  in  4*CHANNELS  per-master beat count.
m_wdata  in  DATA_W*CHANNELS  per-master write data.
m_wbyte_enable  in  (DATA_W/8)*CHANNELS  per-master byte enables.
m_transaction_done  out  CHANNELS  done pulse, routed to the granted master only.
m_transaction_response  out  3*CHANNELS  response, valid with done on the granted slice; 0 elsewhere.
m_rdata  out  DATA_W  read data, broadcast to all masters.
s_transaction, s_cmd, s_address, s_burstcount, s_wdata, s_wbyte_enable  out  1/3/ADDR_W/4/DATA_W/DATA_W/8  slave side, muxed from the granted master.
s_transaction_done  in  1  slave beat done.
s_transaction_response  in  3  slave response.
s_rdata  in  DATA_W  slave read data.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, grant=0, beat_cnt=0, rr_ptr=0.
  - All outputs 0.
- FSM has two states, IDLE and ACTIVE.
- IDLE:
  - s_transaction=0.
  - If any m_transaction bit is set, the picker selects a winner. Register grant=winner and beats=max(m_burstcount[winner],1), clear beat_cnt, and go to ACTIVE.
  - Arbitration latency: s_transaction rises 1 cycle after the request is seen.
- ACTIVE:
  - s_* signals = slice[grant]; s_transaction = m_transaction[grant].
  - s_transaction_done/s_transaction_response are forwarded combinationally to slice[grant]; all other slices read 0.
  - Each s_transaction_done increments beat_cnt.
  - Burst ends on the done where beat_cnt+1==beats, or on any done with response != OKAY (0). Go to IDLE next cycle.
  - On burst end, rr_ptr = grant+1, wrapping at CHANNELS.
- One mandatory IDLE bubble between grants, including when the same master requests again.
- Round-robin: the search starts at rr_ptr and wraps modulo CHANNELS; the first requester found wins. Fixed mode ignores rr_ptr.
- Masters must hold m_transaction and their signals stable until their last done.
  - If m_transaction[grant] drops in ACTIVE, the arbiter returns to IDLE next cycle.
  - rr_ptr is not updated on such an abort.
  - s_transaction follows the drop immediately (combinational).
- Requests from non-granted masters are ignored until the next IDLE; no done ever reaches them.
- burstcount 0 is treated as 1 beat. beat_cnt is 4 bits; beats ≤ 15, so no wrap.
- Reset mid-burst aborts immediately: s_transaction=0 the cycle after. The slave must tolerate this.
- Done arriving in IDLE (protocol violation) is dropped; no master sees it.

Decomposition:
- armleocpu_bus.vh (shared header):
  - Command codes (NONE/READ/WRITE).
  - Response codes (OKAY=0, non-zero = error/fault).
  - State encodings (IDLE, ACTIVE).
- Sub-module armleocpu_rr_picker:
  - Inputs: request vector and start pointer.
  - Outputs: winner index and valid.
  - Purely combinational; reused in fixed mode with pointer tied to 0.

Test Plan:
- Single read, CHANNELS=2: m0 req cmd=READ addr=0x100 burst=1, slave done resp=0 rdata=0xDEADBEEF two cycles after s_transaction → m_transaction_done[0]=1, m_rdata=0xDEADBEEF, m_transaction_done[1]=0; IDLE next cycle.
- Burst hold: m1 burst=4 while m0 requests continuously → 4 dones routed to m1 only; s_address stays m1's throughout; m0 is granted after one IDLE bubble.
- Round-robin fairness: m0 and m1 both request continuously with burst=1 → grants alternate 0,1,0,1. With ROUND_ROBIN=0 → always grant 0.
- Error early termination: m0 burst=8, slave returns resp=3 on beat 2 → burst ends after beat 2; m0 sees done with resp=3; the arbiter grants the next requester.
- Abort and reset: m0 drops transaction mid-burst → IDLE next cycle, rr_ptr unchanged. rst_n=0 during a burst → all outputs 0 next cycle; grant=0 after release.
- CHANNELS=4 wrap: requests on 3 and 1 with rr_ptr=2 → grant 3 first, then 1.

Source files
------------

// File: rtl/armleocpu_bus_arbiter_pkg.sv
// Shared definitions for the core memory bus arbiter: command/response codes,
// FSM state encodings and the burst-length helper.
package armleocpu_bus_arbiter_pkg;

  localparam int CMD_W   = 3;
  localparam int RESP_W  = 3;
  localparam int BURST_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE  = 3'd0,
    CMD_READ  = 3'd1,
    CMD_WRITE = 3'd2
  } bus_cmd_t;

  // Any non-zero response is an error/fault and terminates the burst.
  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 3'd0,
    RESP_EXOKAY = 3'd1,
    RESP_SLVERR = 3'd2,
    RESP_DECERR = 3'd3
  } bus_resp_t;

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_ACTIVE = 1'b1;

  // A burstcount of zero still moves one beat.
  function automatic logic [BURST_W-1:0] effective_beats(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/armleocpu_bus_arbiter_rr_picker.sv
// Combinational first-requester search starting at a given index and wrapping
// modulo CHANNELS; a start of zero gives fixed lowest-index priority.
module armleocpu_rr_picker #(
  parameter int CHANNELS = 2,
  parameter int IDX_W    = 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    start,
  output logic [IDX_W-1:0]    winner,
  output logic                valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(start) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/armleocpu_bus_arbiter.sv
// N-master to 1-slave arbiter for the core memory bus. The grant is held for a
// whole burst and every grant is separated by one IDLE cycle.
module armleocpu_bus_arbiter
  import armleocpu_bus_arbiter_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 34,
  parameter int DATA_W      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic [CHANNELS-1:0]          m_transaction,
  input  logic [3*CHANNELS-1:0]        m_cmd,
  input  logic [ADDR_W*CHANNELS-1:0]   m_address,
  input  logic [4*CHANNELS-1:0]        m_burstcount,
  input  logic [DATA_W*CHANNELS-1:0]   m_wdata,
  input  logic [(DATA_W/8)*CHANNELS-1:0] m_wbyte_enable,
  output logic [CHANNELS-1:0]          m_transaction_done,
  output logic [3*CHANNELS-1:0]        m_transaction_response,
  output logic [DATA_W-1:0]            m_rdata,

  output logic                         s_transaction,
  output logic [2:0]                   s_cmd,
  output logic [ADDR_W-1:0]            s_address,
  output logic [3:0]                   s_burstcount,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wbyte_enable,
  input  logic                         s_transaction_done,
  input  logic [2:0]                   s_transaction_response,
  input  logic [DATA_W-1:0]            s_rdata
);

  localparam int IDX_W = $clog2(CHANNELS);
  localparam int BE_W  = DATA_W / 8;

  logic [0:0]         state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   rr_ptr;
  logic [BURST_W-1:0] beats;
  logic [BURST_W-1:0] beat_cnt;

  logic [IDX_W-1:0]   pick_start;
  logic [IDX_W-1:0]   pick_winner;
  logic               pick_valid;
  logic [BURST_W-1:0] win_burst;
  logic               burst_last;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(CHANNELS - 1)) return '0;
    return p + 1'b1;
  endfunction

  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      assign pick_start = rr_ptr;
    end else begin : g_fixed
      assign pick_start = '0;
    end
  endgenerate

  armleocpu_rr_picker #(
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req    (m_transaction),
    .start  (pick_start),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    win_burst = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pick_winner == IDX_W'(k)) win_burst = m_burstcount[4*k +: 4];
    end
  end

  // An error response ends the burst early, whatever the beat count.
  assign burst_last = (BURST_W'(beat_cnt + 1'b1) == beats) ||
                      (s_transaction_response != RESP_OKAY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= STATE_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beats    <= BURST_W'(1);
      beat_cnt <= '0;
    end else if (state == STATE_IDLE) begin
      if (pick_valid) begin
        grant    <= pick_winner;
        beats    <= effective_beats(win_burst);
        beat_cnt <= '0;
        state    <= STATE_ACTIVE;
      end
    end else begin
      if (s_transaction_done && burst_last) begin
        state    <= STATE_IDLE;
        rr_ptr   <= next_ptr(grant);
        beat_cnt <= BURST_W'(beat_cnt + 1'b1);
      end else if (!m_transaction[grant]) begin
        // Master abandoned the burst: release without advancing fairness.
        state <= STATE_IDLE;
      end else if (s_transaction_done) begin
        beat_cnt <= BURST_W'(beat_cnt + 1'b1);
      end
    end
  end

  always_comb begin
    s_transaction          = 1'b0;
    s_cmd                  = CMD_NONE;
    s_address              = '0;
    s_burstcount           = '0;
    s_wdata                = '0;
    s_wbyte_enable         = '0;
    m_transaction_done     = '0;
    m_transaction_response = '0;
    m_rdata                = '0;
    if (state == STATE_ACTIVE) begin
      m_rdata = s_rdata;
      for (int k = 0; k < CHANNELS; k++) begin
        if (grant == IDX_W'(k)) begin
          s_transaction                  = m_transaction[k];
          s_cmd                          = m_cmd[3*k +: 3];
          s_address                      = m_address[ADDR_W*k +: ADDR_W];
          s_burstcount                   = m_burstcount[4*k +: 4];
          s_wdata                        = m_wdata[DATA_W*k +: DATA_W];
          s_wbyte_enable                 = m_wbyte_enable[BE_W*k +: BE_W];
          m_transaction_done[k]          = s_transaction_done;
          m_transaction_response[3*k +: 3] = s_transaction_response;
        end
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_bus_arbiter.sv
// Bench for armleocpu_bus_arbiter: a cycle table on a 2-channel round-robin
// instance plus short sequences for fixed priority and 4-channel wrap-around.
module tb_armleocpu_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [31:0] srdata;

  // Two-channel stimulus shared by the round-robin and fixed-priority instances
  logic [1:0]  m2_trans;
  logic [5:0]  m2_cmd;
  logic [67:0] m2_addr;
  logic [7:0]  m2_bc;
  logic [63:0] m2_wdata;
  logic [7:0]  m2_be;

  logic [1:0]  a_mdone;
  logic [5:0]  a_mresp;
  logic [31:0] a_mrdata;
  logic        a_strans;
  logic [2:0]  a_scmd;
  logic [33:0] a_saddr;
  logic [3:0]  a_sbc;
  logic [31:0] a_swdata;
  logic [3:0]  a_sbe;
  logic        a_sdone;
  logic [2:0]  a_sresp;

  logic [1:0]  b_mdone;
  logic [5:0]  b_mresp;
  logic [31:0] b_mrdata;
  logic        b_strans;
  logic [2:0]  b_scmd;
  logic [33:0] b_saddr;
  logic [3:0]  b_sbc;
  logic [31:0] b_swdata;
  logic [3:0]  b_sbe;

  logic [3:0]   c_trans;
  logic [11:0]  c_cmd;
  logic [135:0] c_addr;
  logic [15:0]  c_bc;
  logic [127:0] c_wdata;
  logic [15:0]  c_be;
  logic [3:0]   c_mdone;
  logic [11:0]  c_mresp;
  logic [31:0]  c_mrdata;
  logic         c_strans;
  logic [2:0]   c_scmd;
  logic [33:0]  c_saddr;
  logic [3:0]   c_sbc;
  logic [31:0]  c_swdata;
  logic [3:0]   c_sbe;

  armleocpu_bus_arbiter #(.CHANNELS(2), .ADDR_W(34), .DATA_W(32), .ROUND_ROBIN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_transaction(m2_trans), .m_cmd(m2_cmd), .m_address(m2_addr),
    .m_burstcount(m2_bc), .m_wdata(m2_wdata), .m_wbyte_enable(m2_be),
    .m_transaction_done(a_mdone), .m_transaction_response(a_mresp), .m_rdata(a_mrdata),
    .s_transaction(a_strans), .s_cmd(a_scmd), .s_address(a_saddr),
    .s_burstcount(a_sbc), .s_wdata(a_swdata), .s_wbyte_enable(a_sbe),
    .s_transaction_done(a_sdone), .s_transaction_response(a_sresp), .s_rdata(srdata)
  );

  // Slave that completes every beat in the cycle it is presented
  armleocpu_bus_arbiter #(.CHANNELS(2), .ADDR_W(34), .DATA_W(32), .ROUND_ROBIN(0)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .m_transaction(m2_trans), .m_cmd(m2_cmd), .m_address(m2_addr),
    .m_burstcount(m2_bc), .m_wdata(m2_wdata), .m_wbyte_enable(m2_be),
    .m_transaction_done(b_mdone), .m_transaction_response(b_mresp), .m_rdata(b_mrdata),
    .s_transaction(b_strans), .s_cmd(b_scmd), .s_address(b_saddr),
    .s_burstcount(b_sbc), .s_wdata(b_swdata), .s_wbyte_enable(b_sbe),
    .s_transaction_done(b_strans), .s_transaction_response(3'd0), .s_rdata(srdata)
  );

  armleocpu_bus_arbiter #(.CHANNELS(4), .ADDR_W(34), .DATA_W(32), .ROUND_ROBIN(1)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .m_transaction(c_trans), .m_cmd(c_cmd), .m_address(c_addr),
    .m_burstcount(c_bc), .m_wdata(c_wdata), .m_wbyte_enable(c_be),
    .m_transaction_done(c_mdone), .m_transaction_response(c_mresp), .m_rdata(c_mrdata),
    .s_transaction(c_strans), .s_cmd(c_scmd), .s_address(c_saddr),
    .s_burstcount(c_sbc), .s_wdata(c_swdata), .s_wbyte_enable(c_sbe),
    .s_transaction_done(c_strans), .s_transaction_response(3'd0), .s_rdata(srdata)
  );

  typedef struct packed {
    logic       rst_n;
    logic [1:0] req;
    logic [3:0] bc0;
    logic [3:0] bc1;
    logic       sdone;
    logic [2:0] sresp;
    logic       e_strans;
    logic [1:0] e_sel;    // 0: no slice on the slave side, 1: master 0, 2: master 1
    logic [1:0] e_mdone;
    logic [5:0] e_mresp;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input int r, input int q, input int b0, input int b1,
                              input int d, input int rs, input int es, input int sel,
                              input int md, input int mr);
    vec_t v;
    v.rst_n    = 1'(r);
    v.req      = 2'(q);
    v.bc0      = 4'(b0);
    v.bc1      = 4'(b1);
    v.sdone    = 1'(d);
    v.sresp    = 3'(rs);
    v.e_strans = 1'(es);
    v.e_sel    = 2'(sel);
    v.e_mdone  = 2'(md);
    v.e_mresp  = 6'(mr);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [33:0] ea;
    logic [2:0]  ec;
    logic [3:0]  eb;
    logic [31:0] ew;
    logic [3:0]  ebe;
    vec_t v;

    srdata   = 32'hDEADBEEF;
    rst_n    = 1'b0;
    m2_trans = 2'b00;
    m2_cmd   = {3'd2, 3'd1};
    m2_addr  = {34'h200, 34'h100};
    m2_bc    = 8'h11;
    m2_wdata = {32'hB1B1_0001, 32'hA0A0_0000};
    m2_be    = {4'h3, 4'hF};
    a_sdone  = 1'b0;
    a_sresp  = 3'd0;
    c_trans  = 4'b0000;
    c_cmd    = {4{3'd1}};
    c_addr   = {34'h400, 34'h300, 34'h200, 34'h100};
    c_bc     = 16'h1111;
    c_wdata  = {32'h3, 32'h2, 32'h1, 32'h0};
    c_be     = 16'hFFFF;

    // rst, req, bc0, bc1, done, resp | s_trans, sel, m_done, m_resp
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));  // reset state
    vq.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0));  // single read, m0 seen in IDLE
    vq.push_back(mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(1, 1, 1, 1, 1, 0, 1, 1, 1, 0));  // done two cycles in
    vq.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 1, 4, 0, 0, 0, 0, 0, 0));  // burst hold, rr_ptr=1 -> m1
    vq.push_back(mk(1, 3, 1, 4, 1, 0, 1, 2, 2, 0));
    vq.push_back(mk(1, 3, 1, 4, 0, 0, 1, 2, 0, 0));
    vq.push_back(mk(1, 3, 1, 4, 1, 0, 1, 2, 2, 0));
    vq.push_back(mk(1, 3, 1, 4, 1, 0, 1, 2, 2, 0));
    vq.push_back(mk(1, 3, 1, 4, 1, 0, 1, 2, 2, 0));  // fourth beat ends burst
    vq.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 0, 0));  // bubble, then alternation
    vq.push_back(mk(1, 3, 1, 1, 1, 0, 1, 1, 1, 0));
    vq.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 1, 1, 1, 0, 1, 2, 2, 0));
    vq.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 1, 1, 1, 0, 1, 1, 1, 0));
    vq.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 1, 1, 1, 0, 1, 2, 2, 0));
    vq.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0, 0));  // m0 burst 8
    vq.push_back(mk(1, 1, 8, 1, 1, 0, 1, 1, 1, 0));
    vq.push_back(mk(1, 1, 8, 1, 1, 3, 1, 1, 1, 3));  // error on beat 2
    vq.push_back(mk(1, 3, 8, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 8, 1, 1, 0, 1, 2, 2, 0));  // next requester m1
    vq.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 0));  // abort scenario
    vq.push_back(mk(1, 1, 4, 1, 1, 0, 1, 1, 1, 0));
    vq.push_back(mk(1, 0, 4, 1, 0, 0, 0, 1, 0, 0));  // m0 drops mid-burst
    vq.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 0, 0));  // rr_ptr still 0 -> m0
    vq.push_back(mk(1, 3, 1, 1, 1, 0, 1, 1, 1, 0));
    vq.push_back(mk(1, 3, 1, 4, 0, 0, 0, 0, 0, 0));  // m1 burst, then reset
    vq.push_back(mk(1, 3, 1, 4, 1, 0, 1, 2, 2, 0));
    vq.push_back(mk(0, 3, 1, 4, 0, 0, 1, 2, 0, 0));
    vq.push_back(mk(0, 3, 1, 4, 0, 0, 0, 0, 0, 0));  // outputs cleared
    vq.push_back(mk(1, 3, 1, 4, 0, 0, 0, 0, 0, 0));  // rr_ptr reset -> m0
    vq.push_back(mk(1, 3, 1, 4, 1, 0, 1, 1, 1, 0));
    vq.push_back(mk(1, 0, 1, 4, 1, 3, 0, 0, 0, 0));  // stray done in IDLE
    vq.push_back(mk(1, 0, 1, 4, 0, 0, 0, 0, 0, 0));

    repeat (2) tick();

    foreach (vq[i]) begin
      v        = vq[i];
      rst_n    = v.rst_n;
      m2_trans = v.req;
      m2_bc    = {v.bc1, v.bc0};
      a_sdone  = v.sdone;
      a_sresp  = v.sresp;
      #3;
      case (v.e_sel)
        2'd1:    begin ea = 34'h100; ec = 3'd1; eb = v.bc0; ew = 32'hA0A0_0000; ebe = 4'hF; end
        2'd2:    begin ea = 34'h200; ec = 3'd2; eb = v.bc1; ew = 32'hB1B1_0001; ebe = 4'h3; end
        default: begin ea = '0; ec = '0; eb = '0; ew = '0; ebe = '0; end
      endcase
      chk($sformatf("row%0d s_transaction", i), 64'(a_strans), 64'(v.e_strans));
      chk($sformatf("row%0d s_address", i), 64'(a_saddr), 64'(ea));
      chk($sformatf("row%0d s_cmd", i), 64'(a_scmd), 64'(ec));
      chk($sformatf("row%0d s_burstcount", i), 64'(a_sbc), 64'(eb));
      chk($sformatf("row%0d s_wdata", i), 64'(a_swdata), 64'(ew));
      chk($sformatf("row%0d s_wbyte_enable", i), 64'(a_sbe), 64'(ebe));
      chk($sformatf("row%0d m_transaction_done", i), 64'(a_mdone), 64'(v.e_mdone));
      chk($sformatf("row%0d m_transaction_response", i), 64'(a_mresp), 64'(v.e_mresp));
      chk($sformatf("row%0d m_rdata", i), 64'(a_mrdata),
          (v.e_sel != 2'd0) ? 64'hDEADBEEF : 64'h0);
      tick();
    end

    // Fixed priority: both masters request continuously, only master 0 is ever granted
    rst_n    = 1'b0;
    m2_trans = 2'b11;
    m2_bc    = 8'h11;
    a_sdone  = 1'b0;
    a_sresp  = 3'd0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #3;
      chk($sformatf("fixed%0d s_transaction", i), 64'(b_strans), 64'(i % 2));
      chk($sformatf("fixed%0d m_transaction_done", i), 64'(b_mdone), (i % 2 == 1) ? 64'h1 : 64'h0);
      if (i % 2 == 1) chk($sformatf("fixed%0d s_address", i), 64'(b_saddr), 64'h100);
      tick();
    end
    m2_trans = 2'b00;

    // Four channels: a grant to master 1 leaves rr_ptr=2, then 3 wins before 1
    c_trans = 4'b0010;
    #3; chk("wrap c0 s_transaction", 64'(c_strans), 64'h0);
    tick();
    #3; chk("wrap c1 s_address", 64'(c_saddr), 64'h200);
    tick();
    c_trans = 4'b1010;
    #3; chk("wrap c2 s_transaction", 64'(c_strans), 64'h0);
    tick();
    #3; chk("wrap c3 s_address", 64'(c_saddr), 64'h400);
    chk("wrap c3 m_transaction_done", 64'(c_mdone), 64'h8);
    tick();
    #3; chk("wrap c4 s_transaction", 64'(c_strans), 64'h0);
    tick();
    #3; chk("wrap c5 s_address", 64'(c_saddr), 64'h200);
    chk("wrap c5 m_transaction_done", 64'(c_mdone), 64'h2);
    tick();
    c_trans = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
